sata_cmd_sequencer: RTL and testbench
=====================================

# sata_cmd_sequencer

Command sequencer and two-port arbiter in front of `sata_stack`'s user command interface. It accepts sector-level read/write jobs from two requesters and grants them round-robin. It splits each job into chunks of at most `MAX_SECTORS` and drives `write_data_en`/`read_data_en`, `sector_count` and `sector_address` for each chunk. It watches `sata_ready`/`sata_busy`/`d2h_status` to detect completion, errors and hangs, and recovers from a hang by pulsing `command_layer_reset`.

## Interface
- `MAX_SECTORS`, 256: largest chunk issued per command; legal range 1..65535.
- `TIMEOUT_CYCLES`, 1000000: cycles allowed per chunk, counted from issue until completion.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid[1:0]` in 2: job request from requester n, held until acked.
- `req_write[1:0]` in 2: per-port direction; 1 = write to the drive, 0 = read.
- `req_addr0`, `req_addr1` in 48: starting LBA of the job.
- `req_count0`, `req_count1` in 32: total sectors in the job.
- `req_ack[1:0]` out 2: one-cycle pulse when the job is accepted.
- `job_done[1:0]` out 2: one-cycle pulse when the job ends.
- `job_error` out 1: valid alongside `job_done`; 1 means the job failed.
- `job_sectors` out 32: sectors completed successfully; valid alongside `job_done`.
- `linkup`, `sata_ready`, `sata_busy` in 1 each: status from `sata_stack`.
- `d2h_status` in 8: drive status from `sata_stack`; bit 0 is ERR.
- `write_data_en`, `read_data_en` out 1 each: command enables to `sata_stack`.
- `sector_count` out 16: chunk size presented to `sata_stack`.
- `sector_address` out 48: chunk LBA presented to `sata_stack`.
- `command_layer_reset` out 1: reset pulse to the command layer.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, RECOVER, FINISH.
- IDLE:
  - Requires `linkup & sata_ready`, otherwise no grant is made.
  - If any `req_valid` is set, grant round-robin and pulse `req_ack[n]` in the same cycle as the IDLE→ISSUE transition.
  - Latch addr, count and dir into working registers.
  - After reset the priority pointer favours port 0. After each grant it points at the other port.
- Zero-length job (`count == 0`): go straight to FINISH with `job_error = 0`, `job_sectors = 0`. No command is issued.
- ISSUE:
  - Compute `chunk = min(remaining, MAX_SECTORS)` and drive `sector_count`/`sector_address`.
  - Assert the enable for the job direction. Enter WAIT_BUSY.
- WAIT_BUSY: hold the enable and the values until `sata_busy = 1`, then drop the enable. Enter WAIT_DONE.
- WAIT_DONE: wait for `sata_busy = 0 & sata_ready = 1`. Enter CHECK.
- CHECK:
  - If `d2h_status[0] = 1`, go to FINISH with error.
  - Otherwise: `done_sectors += chunk`, `remaining -= chunk`, `addr += chunk`.
  - `addr` wraps modulo 2^48.
  - If `remaining == 0`, go to FINISH; else go to ISSUE.
- Timeout:
  - A per-chunk counter clears on entry to ISSUE and increments in ISSUE, WAIT_BUSY and WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES`, drop the enables and enter RECOVER.
- RECOVER:
  - Assert `command_layer_reset` for 1 cycle, then wait for `sata_ready = 1`. Enter FINISH with error.
  - The partially issued chunk is not counted.
- `linkup` dropping in any active state is treated like a timeout: go to RECOVER immediately.
- FINISH:
  - Pulse `job_done[n]` and present `job_error`/`job_sectors` for 1 cycle. Return to IDLE.
  - A new grant is possible on the following cycle.

## Timing
- Reset values: all outputs 0, including `sector_count`, `sector_address`, `job_sectors` and `busy`. State IDLE; priority pointer at port 0.
- `rst` mid-job: abort the job with no `job_done`, and clear all outputs on the next edge.
- Latency from `req_valid` (while idle and ready) to `req_ack`: 1 cycle.
- Latency from `req_ack` to enable assertion: 1 cycle.
- `sector_count`, `sector_address` and direction are stable from the first cycle of the enable until the enable drops.
- At most one enable is high at any time.
- Latency from `sata_ready` rising in WAIT_DONE to the next chunk's enable: 2 cycles (CHECK, ISSUE).
- Requests arriving during a job are held by the requester and are not acked until IDLE.
- `command_layer_reset` is never asserted except in RECOVER.
- Arithmetic:
  - `remaining` and `done_sectors` are 32-bit.
  - `chunk` is zero-extended to 48 bits for the address add.
  - `sector_count` is `chunk[15:0]`; it is never 0 because `MAX_SECTORS ≤ 65535`.

## Test plan
- Write of 600 sectors on port 0 at LBA 0x10, `MAX_SECTORS = 256` → three write commands: (0x10, 256), (0x110, 256), (0x210, 88). Then `job_done[0]`, `job_error = 0`, `job_sectors = 600`.
- Both ports request on the same cycle right after reset → port 0 acked first, port 1 acked in the cycle after port 0's `job_done`. Repeating with both requesting again → port 0 wins next, since the pointer alternates.
- Read of 4 sectors at LBA 0xFFFF_FFFF_FFFE with `MAX_SECTORS = 2` → chunks issued at 0xFFFF_FFFF_FFFE, then wrapped address 0x0.
- `d2h_status = 0x51` on the second chunk of a 512-sector job → `job_error = 1`, `job_sectors = 256`, no third command issued.
- Model never raises `sata_busy`, with `TIMEOUT_CYCLES = 100` → enable drops after 100 cycles, `command_layer_reset` pulses once. After `sata_ready` returns: `job_done` with `job_error = 1`, `job_sectors = 0`.
- Zero-count request → `req_ack` then `job_done` with no enable asserted. Assert `rst` during WAIT_DONE of another job → all outputs 0 next cycle, no `job_done`.

Source files
------------

// File: rtl/sata_cmd_sequencer_if.sv
// Job handshake from the two requesters plus command/status wiring to sata_stack.
interface sata_cmd_sequencer_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [47:0] req_addr0;
  logic [47:0] req_addr1;
  logic [31:0] req_count0;
  logic [31:0] req_count1;
  logic [1:0]  req_ack;
  logic [1:0]  job_done;
  logic        job_error;
  logic [31:0] job_sectors;
  logic        linkup;
  logic        sata_ready;
  logic        sata_busy;
  logic [7:0]  d2h_status;
  logic        write_data_en;
  logic        read_data_en;
  logic [15:0] sector_count;
  logic [47:0] sector_address;
  logic        command_layer_reset;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_count0, req_count1,
    output linkup, sata_ready, sata_busy, d2h_status,
    input  req_ack, job_done, job_error, job_sectors,
    input  write_data_en, read_data_en, sector_count, sector_address,
    input  command_layer_reset, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_count0, req_count1,
    input  linkup, sata_ready, sata_busy, d2h_status,
    output req_ack, job_done, job_error, job_sectors,
    output write_data_en, read_data_en, sector_count, sector_address,
    output command_layer_reset, busy
  );
endinterface

// File: rtl/sata_cmd_sequencer.sv
// Two-port round-robin job arbiter that splits sector jobs into chunked sata_stack
// commands, tracks completion/errors and recovers hung commands via command_layer_reset.
module sata_cmd_sequencer #(
  parameter int unsigned MAX_SECTORS    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                 clk,
  input logic                 rst,
  sata_cmd_sequencer_if.slave bus
);
  localparam logic [31:0] MAX_CHUNK = 32'(MAX_SECTORS);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, RECOVER, FINISH
  } state_t;

  state_t      state;
  logic        ptr;
  logic        port;
  logic        dir_wr;
  logic        err;
  logic [47:0] addr;
  logic [31:0] remaining;
  logic [31:0] done_sectors;
  logic [31:0] chunk;
  logic [31:0] tmr;

  logic        grant_port;
  logic [31:0] grant_count;
  logic [31:0] cur_chunk;
  logic        link_lost;
  logic        tmr_hit;
  logic        unused_status;

  function automatic logic [31:0] chunk_of(input logic [31:0] rem);
    return (rem < MAX_CHUNK) ? rem : MAX_CHUNK;
  endfunction

  // Only one requester pending wins outright; a tie goes to the priority pointer.
  always_comb begin
    grant_port  = (&bus.req_valid) ? ptr : bus.req_valid[1];
    grant_count = grant_port ? bus.req_count1 : bus.req_count0;
    cur_chunk   = chunk_of(remaining);
    link_lost   = !bus.linkup;
    tmr_hit     = (tmr == TMO_LAST);
  end

  assign unused_status = ^bus.d2h_status[7:1];
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      ptr                     <= 1'b0;
      port                    <= 1'b0;
      err                     <= 1'b0;
      tmr                     <= '0;
      bus.req_ack             <= '0;
      bus.job_done            <= '0;
      bus.job_error           <= 1'b0;
      bus.job_sectors         <= '0;
      bus.write_data_en       <= 1'b0;
      bus.read_data_en        <= 1'b0;
      bus.sector_count        <= '0;
      bus.sector_address      <= '0;
      bus.command_layer_reset <= 1'b0;
    end else begin
      bus.req_ack             <= '0;
      bus.job_done            <= '0;
      bus.job_error           <= 1'b0;
      bus.job_sectors         <= '0;
      bus.command_layer_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.linkup && bus.sata_ready && (|bus.req_valid)) begin
            bus.req_ack[grant_port] <= 1'b1;
            port         <= grant_port;
            ptr          <= ~grant_port;
            dir_wr       <= bus.req_write[grant_port];
            addr         <= grant_port ? bus.req_addr1 : bus.req_addr0;
            remaining    <= grant_count;
            done_sectors <= '0;
            err          <= 1'b0;
            tmr          <= '0;
            state        <= (grant_count == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE, WAIT_BUSY, WAIT_DONE: begin
          tmr <= tmr + 32'd1;
          if (link_lost || tmr_hit) begin
            bus.write_data_en       <= 1'b0;
            bus.read_data_en        <= 1'b0;
            bus.command_layer_reset <= 1'b1;
            err                     <= 1'b1;
            state                   <= RECOVER;
          end else if (state == ISSUE) begin
            chunk              <= cur_chunk;
            bus.sector_count   <= cur_chunk[15:0];
            bus.sector_address <= addr;
            bus.write_data_en  <= dir_wr;
            bus.read_data_en   <= ~dir_wr;
            state              <= WAIT_BUSY;
          end else if (state == WAIT_BUSY) begin
            if (bus.sata_busy) begin
              bus.write_data_en <= 1'b0;
              bus.read_data_en  <= 1'b0;
              state             <= WAIT_DONE;
            end
          end else if (!bus.sata_busy && bus.sata_ready) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (link_lost) begin
            bus.command_layer_reset <= 1'b1;
            err                     <= 1'b1;
            state                   <= RECOVER;
          end else if (bus.d2h_status[0]) begin
            err   <= 1'b1;
            state <= FINISH;
          end else begin
            done_sectors <= done_sectors + chunk;
            remaining    <= remaining - chunk;
            addr         <= addr + {16'd0, chunk};
            tmr          <= '0;
            state        <= (remaining == chunk) ? FINISH : ISSUE;
          end
        end
        // The reset pulse occupies the first RECOVER cycle; only then is ready trusted.
        RECOVER: begin
          if (!bus.command_layer_reset && bus.sata_ready) state <= FINISH;
        end
        FINISH: begin
          bus.job_done[port] <= 1'b1;
          bus.job_error      <= err;
          bus.job_sectors    <= done_sectors;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sata_cmd_sequencer.sv
// Directed and randomized checks of sata_cmd_sequencer against a sector-arithmetic job model
// and a small emulated sata_stack.
module tb_sata_cmd_sequencer;
  localparam int MAXS = 256;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sata_cmd_sequencer_if bus();

  sata_cmd_sequencer #(.MAX_SECTORS(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Emulated drive state and monitor tallies (written only by the model process).
  int          m_phase = 0, m_dly = 0, rec_dly = 0;
  int          clr_pulses = 0, n_two_en = 0, n_unstable = 0;
  bit          prev_en = 1'b0;
  logic [64:0] prev_cmd = '0;
  logic [47:0] q_addr[$];
  logic [15:0] q_cnt[$];
  bit          q_wr[$];

  // Knobs written only by the stimulus process.
  bit m_hang = 1'b0, m_stall = 1'b0;
  int m_err_abs = -1;

  bit          j_wr[2];
  logic [47:0] j_addr[2];
  int          j_cnt[2];
  int          j_err[2];
  int          ptr_m = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.write_data_en && bus.read_data_en) n_two_en++;
      if (prev_en && (bus.write_data_en || bus.read_data_en) &&
          ({bus.sector_count, bus.sector_address, bus.write_data_en} != prev_cmd)) n_unstable++;
    end
    prev_en  = !rst && (bus.write_data_en || bus.read_data_en);
    prev_cmd = {bus.sector_count, bus.sector_address, bus.write_data_en};
    if (rst) begin
      m_phase = 0; rec_dly = 0;
      bus.sata_busy = 1'b0; bus.sata_ready = 1'b1; bus.d2h_status = 8'h50;
    end else if (bus.command_layer_reset) begin
      clr_pulses++;
      m_phase = 0; rec_dly = 4;
      bus.sata_busy = 1'b0; bus.sata_ready = 1'b0;
    end else if (rec_dly > 0) begin
      rec_dly--;
      if (rec_dly == 0) bus.sata_ready = 1'b1;
    end else begin
      case (m_phase)
        0: if (bus.write_data_en || bus.read_data_en) begin
          q_addr.push_back(bus.sector_address);
          q_cnt.push_back(bus.sector_count);
          q_wr.push_back(bus.write_data_en);
          m_phase = 1; m_dly = $urandom_range(0, 3);
        end
        1: if (!m_hang) begin
          if (m_dly == 0) begin
            bus.sata_busy = 1'b1; bus.sata_ready = 1'b0; bus.d2h_status = 8'h50;
            m_phase = 2; m_dly = $urandom_range(0, 6);
          end else m_dly--;
        end
        default: if (!m_stall) begin
          if (m_dly == 0) begin
            bus.sata_busy = 1'b0; bus.sata_ready = 1'b1;
            if (q_cnt.size() - 1 == m_err_abs) bus.d2h_status = 8'h51;
            m_phase = 0;
          end else m_dly--;
        end
      endcase
    end
  end

  task automatic set_job(input int p, input bit wr, input logic [47:0] a, input int cnt, input int e);
    j_wr[p] = wr; j_addr[p] = a; j_cnt[p] = cnt; j_err[p] = e;
  endtask

  task automatic check_idle(input string t);
    check({t, "_ack"}, bus.req_ack, 0);
    check({t, "_done"}, bus.job_done, 0);
    check({t, "_jerr"}, bus.job_error, 0);
    check({t, "_jsec"}, bus.job_sectors, 0);
    check({t, "_en"}, {bus.write_data_en, bus.read_data_en}, 0);
    check({t, "_scnt"}, bus.sector_count, 0);
    check({t, "_saddr"}, bus.sector_address, 0);
    check({t, "_clr"}, bus.command_layer_reset, 0);
    check({t, "_busy"}, bus.busy, 0);
  endtask

  // Raise the requested ports with the prepared jobs and follow every job to completion.
  task automatic serve(input logic [1:0] which);
    logic [1:0]  pend, stray;
    logic [47:0] ea;
    int p, cyc, base, full, nexp, ec, clr0;
    int done_exp;
    bit err_exp;
    pend = which;
    bus.req_write  = {j_wr[1], j_wr[0]};
    bus.req_addr0  = j_addr[0];
    bus.req_addr1  = j_addr[1];
    bus.req_count0 = 32'(j_cnt[0]);
    bus.req_count1 = 32'(j_cnt[1]);
    bus.req_valid  = which;
    while (pend != 2'b00) begin
      p = (pend == 2'b11) ? ptr_m : (pend[1] ? 1 : 0);
      clr0 = clr_pulses;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (bus.req_ack == 2'b00 && cyc < 2000);
      check("ack_latency", cyc, 1);
      check("ack_port", bus.req_ack, 64'(1 << p));
      base = q_cnt.size();
      m_err_abs = (j_err[p] < 0) ? -1 : base + j_err[p];
      bus.req_valid[p] = 1'b0;
      pend[p] = 1'b0;
      ptr_m = 1 - p;
      if (m_hang) begin
        cyc = 0;
        do begin @(negedge clk); cyc++; end
        while ((bus.write_data_en || bus.read_data_en) && cyc < 1000);
        check("timeout_len", cyc, TMO);
      end
      stray = 2'b00;
      cyc = 0;
      do begin @(negedge clk); cyc++; stray |= bus.req_ack; end
      while (bus.job_done == 2'b00 && cyc < 20000);
      full = (j_cnt[p] + MAXS - 1) / MAXS;
      if (m_hang) begin
        nexp = 1; done_exp = 0; err_exp = 1'b1;
      end else if (j_err[p] >= 0 && j_err[p] < full) begin
        nexp = j_err[p] + 1; done_exp = j_err[p] * MAXS; err_exp = 1'b1;
      end else begin
        nexp = full; done_exp = j_cnt[p]; err_exp = 1'b0;
      end
      check("done_port", bus.job_done, 64'(1 << p));
      check("job_error", bus.job_error, err_exp);
      check("job_sectors", bus.job_sectors, 64'(done_exp));
      check("no_ack_mid_job", stray, 0);
      check("clr_pulses", clr_pulses - clr0, m_hang ? 1 : 0);
      check("cmd_total", q_cnt.size() - base, nexp);
      for (int k = 0; k < nexp && base + k < q_cnt.size(); k++) begin
        ea = j_addr[p] + 48'(k * MAXS);
        ec = (j_cnt[p] - k * MAXS < MAXS) ? j_cnt[p] - k * MAXS : MAXS;
        check("cmd_addr", q_addr[base + k], ea);
        check("cmd_sectors", q_cnt[base + k], 64'(ec));
        check("cmd_dir", q_wr[base + k], j_wr[p]);
      end
    end
  endtask

  initial begin
    int cyc;
    logic [1:0] seen;
    int r;
    logic [47:0] ra;
    bus.req_valid = 2'b00; bus.req_write = 2'b00;
    bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_count0 = '0; bus.req_count1 = '0;
    bus.linkup = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    ptr_m = 0;

    // Simultaneous requests after reset; port 0 carries the 600-sector write.
    set_job(0, 1'b1, 48'h10, 600, -1);
    set_job(1, 1'b0, 48'h2000, 5, -1);
    serve(2'b11);

    // Tie again: pointer alternated back to port 0; its read wraps the LBA space.
    set_job(0, 1'b0, 48'hFFFF_FFFF_FF80, 260, -1);
    set_job(1, 1'b1, 48'h1234, 0, -1);
    serve(2'b11);

    // Drive error on the second chunk of a 512-sector write.
    set_job(1, 1'b1, 48'h4000, 512, 1);
    serve(2'b10);

    // Drive never goes busy: per-chunk timeout and recovery.
    m_hang = 1'b1;
    set_job(0, 1'b1, 48'h777, 50, -1);
    serve(2'b01);
    m_hang = 1'b0;

    // Reset while the drive is executing a chunk.
    bus.req_write = 2'b01; bus.req_addr0 = 48'h5000; bus.req_count0 = 32'd600;
    bus.req_valid = 2'b01;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.req_ack == 2'b00 && cyc < 100);
    check("rstjob_ack", bus.req_ack, 2'b01);
    bus.req_valid = 2'b00;
    m_stall = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end
    while (!(bus.sata_busy && !bus.write_data_en && !bus.read_data_en) && cyc < 200);
    check("rstjob_active", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    m_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    seen = 2'b00;
    repeat (6) begin @(negedge clk); seen |= bus.job_done; end
    check("no_done_after_rst", seen, 0);
    set_job(0, 1'b0, 48'h9000, 3, -1);
    set_job(1, 1'b0, 48'hA000, 300, -1);
    serve(2'b11);

    // Randomized jobs, port mixes, lengths, addresses and error injections.
    for (int it = 0; it < 20; it++) begin
      for (int q = 0; q < 2; q++) begin
        r  = $urandom_range(0, 9);
        ra = {16'($urandom), 32'($urandom)};
        if (r == 1) ra = 48'hFFFF_FFFF_FF00 + 48'($urandom_range(0, 255));
        set_job(q, 1'($urandom_range(0, 1)), ra,
                (r == 0) ? 0 : $urandom_range(1, 800),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1);
      end
      serve(2'($urandom_range(1, 3)));
    end

    check("two_enables_seen", n_two_en, 0);
    check("cmd_unstable_seen", n_unstable, 0);
    check("clr_total", clr_pulses, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
